// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: pin sync/filter, 11-bit frame deserialiser, E0/F0 prefix decode, 32-bit key word.
// Optional feature: define PS2_RX_TYPEMATIC_FILTER_EN to drop repeated make codes (keyboard auto-repeat).
module ps2_rx_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2Clk,
  input  logic        ps2Data,
  input  logic        rdAck,
  output logic [31:0] keyData,
  output logic        frameErr
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e state, state_n;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   s_clk, s_dat;
  logic                   filt;
  logic [FCW-1:0]         fcnt;
  logic                   fall;

  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   par;
  logic [TCW-1:0]         tcnt;

  logic                   stop_ok, stop_bad, tmo;
  logic                   ext, brk;
  logic                   is_e0, is_f0, drop, post;

  logic                   kvalid, kovr, krel, kext;
  logic [7:0]             kcode;

  // Synchronisers preload to 1 so the bus reads as idle out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2Clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2Data};
    end
  end

  assign s_clk = clk_sync[SYNC_STAGES-1];
  assign s_dat = dat_sync[SYNC_STAGES-1];

  // Filtered clock flips once FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (s_clk == filt) begin
      fcnt <= '0;
    end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
      filt <= s_clk;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // Asserted in the cycle the filtered clock is about to drop to 0.
  assign fall = filt & ~s_clk & (fcnt == FCW'(FILTER_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    tmo      = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!s_dat) state_n = DATA;
        DATA:    if (bitcnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (s_dat && par) stop_ok  = 1'b1;
          else              stop_bad = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TCW'(TIMEOUT_CYCLES)) begin
      tmo     = 1'b1;
      state_n = IDLE;
    end
  end

  // par accumulates data and parity bits; 1 means an odd count of ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          bitcnt <= '0;
          par    <= 1'b0;
        end
        DATA: begin
          shreg <= {s_dat, shreg[7:1]};
          par   <= par ^ s_dat;
          if (bitcnt != 3'd7) bitcnt <= bitcnt + 3'd1;
        end
        PARITY:  par <= par ^ s_dat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fall || state == IDLE) tcnt <= '0;
    else if (tcnt != TCW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
  end

  assign is_e0 = (shreg == 8'hE0);
  assign is_f0 = (shreg == 8'hF0);

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;

  assign drop = ~brk & ({ext, shreg} == last_make);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_make <= 9'h1FF;
    end else if (stop_ok && !is_e0 && !is_f0) begin
      if (brk) begin
        if ({ext, shreg} == last_make) last_make <= 9'h1FF;
      end else begin
        last_make <= {ext, shreg};
      end
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign post = stop_ok & ~is_e0 & ~is_f0 & ~drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (stop_bad || tmo) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (stop_ok) begin
      if (is_e0) begin
        ext <= 1'b1;
      end else if (is_f0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // A post in the same cycle as rdAck wins; overrun only when the old word is left unread.
  always_ff @(posedge clk) begin
    if (reset) begin
      kvalid <= 1'b0;
      kovr   <= 1'b0;
      krel   <= 1'b0;
      kext   <= 1'b0;
      kcode  <= '0;
    end else if (post) begin
      kvalid <= 1'b1;
      kovr   <= kvalid & ~rdAck;
      krel   <= brk;
      kext   <= ext;
      kcode  <= shreg;
    end else if (rdAck && kvalid) begin
      kvalid <= 1'b0;
      kovr   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) frameErr <= 1'b0;
    else       frameErr <= stop_bad | tmo;
  end

  assign keyData = {kvalid, kovr, 20'b0, krel, kext, kcode};

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed table, hand-written corner sequences, randomized frames vs. a behavioural model.
module tb_ps2_rx_ctrl;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2Clk = 1'b1;
  logic        ps2Data = 1'b1;
  logic        rdAck = 1'b0;
  logic [31:0] keyData;
  logic        frameErr;

  ps2_rx_ctrl #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .rdAck(rdAck), .keyData(keyData), .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int err_seen = 0;
  int posts = 0;
  logic [31:0] prev_kd = '0;

  always @(negedge clk) begin
    if (frameErr) err_seen++;
    if (keyData != prev_kd && keyData[31]) posts++;
    prev_kd = keyData;
  end

  // Behavioural model state
  logic [31:0] m_key;
  logic        m_ext, m_brk;
  logic [8:0]  m_last;
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  localparam bit TYPEMATIC = 1'b1;
`else
  localparam bit TYPEMATIC = 1'b0;
`endif

  task automatic model_reset();
    m_key = '0; m_ext = 0; m_brk = 0; m_last = 9'h1FF;
  endtask

  task automatic model_ack();
    if (m_key[31]) m_key[31:30] = 2'b00;
  endtask

  // Returns expected number of frameErr pulses for this frame.
  task automatic model_frame(input logic [7:0] code, input bit perr, input bit serr, output int errs);
    bit drop;
    errs = 0;
    if (perr || serr) begin
      errs = 1; m_ext = 0; m_brk = 0;
    end else if (code == 8'hE0) begin
      m_ext = 1;
    end else if (code == 8'hF0) begin
      m_brk = 1;
    end else begin
      drop = TYPEMATIC && !m_brk && ({m_ext, code} == m_last);
      if (TYPEMATIC) begin
        if (m_brk && {m_ext, code} == m_last) m_last = 9'h1FF;
        else if (!m_brk) m_last = {m_ext, code};
      end
      if (!drop) m_key = {1'b1, m_key[31], 20'b0, m_brk, m_ext, code};
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(3); reset = 1'b0; cyc(2);
  endtask

  task automatic pulse_ack();
    rdAck = 1'b1; cyc(1); rdAck = 1'b0; cyc(1);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2Data = bits[i];
      cyc(10);
      ps2Clk = 1'b0;
      cyc(10);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit perr, input bit serr);
    logic par;
    par = (~^code) ^ perr;
    send_bits({~serr, par, code, 1'b0}, 11);
    cyc(20);
  endtask

  typedef struct {
    logic [7:0]  code;
    bit          perr;
    bit          serr;
    bit          ack;
    logic [31:0] exp_key;
    int          exp_err;
  } vec_t;

  vec_t tbl[9];
  logic [7:0] picks[6];

  initial begin
    int e0, errs, p0;
    logic [7:0] code;
    bit perr, serr, ack;

    tbl[0] = '{8'h1C, 0, 0, 1, 32'h8000001C, 0};
    tbl[1] = '{8'hE0, 0, 0, 1, 32'h0000001C, 0};
    tbl[2] = '{8'hF0, 0, 0, 0, 32'h0000001C, 0};
    tbl[3] = '{8'h75, 0, 0, 0, 32'h80000375, 0};
    tbl[4] = '{8'h1C, 1, 0, 1, 32'h00000375, 1};
    tbl[5] = '{8'h1B, 0, 0, 0, 32'h8000001B, 0};
    tbl[6] = '{8'h1C, 0, 0, 1, 32'h8000001C, 0};
    tbl[7] = '{8'h32, 0, 0, 0, 32'hC0000032, 0};
    tbl[8] = '{8'h55, 0, 1, 1, 32'h00000032, 1};
    picks = '{8'h1C, 8'h1B, 8'h32, 8'hE0, 8'hF0, 8'h75};

    do_reset();
    model_reset();
    chk("reset_keyData", keyData, 32'h0);
    chk("reset_frameErr", {31'b0, frameErr}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].ack) begin pulse_ack(); model_ack(); end
      e0 = err_seen;
      send_frame(tbl[i].code, tbl[i].perr, tbl[i].serr);
      model_frame(tbl[i].code, tbl[i].perr, tbl[i].serr, errs);
      chk($sformatf("tbl%0d_key", i), keyData, tbl[i].exp_key);
      chk($sformatf("tbl%0d_err", i), err_seen - e0, tbl[i].exp_err);
    end

    pulse_ack(); model_ack();
    chk("ack_clears_flags", keyData, 32'h00000032);
    pulse_ack();
    chk("ack_while_invalid", keyData, 32'h00000032);

    // Timeout mid-frame after an E0 prefix: ext must be dropped
    send_frame(8'hE0, 0, 0);
    model_frame(8'hE0, 0, 0, errs);
    e0 = err_seen;
    send_bits(11'b000_0001_0100, 6);
    cyc(TMO + 60);
    m_ext = 0; m_brk = 0;
    chk("timeout_err", err_seen - e0, 1);
    chk("timeout_key", keyData, 32'h00000032);
    send_frame(8'h1C, 0, 0);
    model_frame(8'h1C, 0, 0, errs);
    chk("after_timeout_key", keyData, 32'h8000001C);

    // Reset in the middle of a frame: silent abort
    e0 = err_seen;
    send_bits(11'b000_0011_0010, 4);
    do_reset();
    model_reset();
    cyc(TMO + 60);
    chk("midreset_key", keyData, 32'h0);
    chk("midreset_err", err_seen - e0, 0);
    send_frame(8'h1B, 0, 0);
    model_frame(8'h1B, 0, 0, errs);
    chk("after_midreset_key", keyData, 32'h8000001B);

    // Auto-repeat sequence: 1C, 1C, F0 1C, 1C
    do_reset();
    model_reset();
    p0 = posts;
    pulse_ack(); send_frame(8'h1C, 0, 0);
    pulse_ack(); send_frame(8'h1C, 0, 0);
    pulse_ack(); send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    chk("typematic_release", keyData, 32'h8000021C);
    pulse_ack(); send_frame(8'h1C, 0, 0);
    chk("typematic_last", keyData, 32'h8000001C);
    chk("typematic_posts", posts - p0, TYPEMATIC ? 3 : 4);
    model_ack(); model_frame(8'h1C, 0, 0, errs);
    model_ack(); model_frame(8'h1C, 0, 0, errs);
    model_ack(); model_frame(8'hF0, 0, 0, errs); model_frame(8'h1C, 0, 0, errs);
    model_ack(); model_frame(8'h1C, 0, 0, errs);
    chk("model_sync", keyData, m_key);

    for (int i = 0; i < 40; i++) begin
      code = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      perr = ($urandom_range(0, 9) == 0);
      serr = ($urandom_range(0, 11) == 0);
      ack  = ($urandom_range(0, 1) == 1);
      if (ack) begin pulse_ack(); model_ack(); end
      e0 = err_seen;
      send_frame(code, perr, serr);
      model_frame(code, perr, serr, errs);
      chk($sformatf("rnd%0d_key(code %02h)", i, code), keyData, m_key);
      chk($sformatf("rnd%0d_err", i), err_seen - e0, errs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
